tpsram_be: RTL and testbench

Parametrised 1-read/1-write synchronous SRAM model with byte-enable writes. It is the next generation of the team's single-port SRAM. It adds:
- independent read and write ports
- a selectable 1- or 2-cycle registered read pipeline with a valid flag
- configurable read-during-write forwarding
- a post-reset hardware clear sequencer

It is used as the register-file, buffer and scratchpad macro model for all subsequent blocks.

---
 rtl/tpsram_be.sv | 145 ++++++++++++++
 tb/tb_tpsram_be.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tpsram_be.sv
// rtl/tpsram_be.sv - 1R/1W byte-enable SRAM model with read pipeline, RDW forwarding and post-reset clear
module tpsram_be #(
    parameter int BW_DATA    = 32,
    parameter int BW_ADDR    = 4,
    parameter int RD_LAT     = 1,
    parameter int BYPASS     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_wen,
    input  logic [BW_ADDR-1:0]   i_waddr,
    input  logic [BW_DATA-1:0]   i_wdata,
    input  logic [BW_DATA/8-1:0] i_wbe,
    input  logic                 i_ren,
    input  logic [BW_ADDR-1:0]   i_raddr,
    output logic [BW_DATA-1:0]   o_rdata,
    output logic                 o_rvalid,
    output logic                 o_init_done
);

    localparam int DEPTH = 2 ** BW_ADDR;
    localparam int NB    = BW_DATA / 8;

    generate
        if ((RD_LAT != 1 && RD_LAT != 2) || (BW_DATA % 8 != 0) || (BW_DATA < 8)) begin : g_bad_param
            $fatal(1, "tpsram_be: RD_LAT must be 1 or 2 and BW_DATA a non-zero multiple of 8");
        end
    endgenerate

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [BW_ADDR-1:0]   clr_addr;
    logic                 mem_clr;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [BW_DATA-1:0]   mem [DEPTH];
    logic [BW_DATA-1:0]   wr_merged;
    logic [BW_DATA-1:0]   rd_word;
    logic                 pipe_vld;
    logic [BW_DATA-1:0]   pipe_data;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= (INIT_CLEAR != 0) ? S_CLEAR : S_READY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_CLEAR && (&clr_addr)) begin
            state_nxt = S_READY;
        end
    end

    // Requests are gated by reset too so an INIT_CLEAR=0 array is not disturbed while held in reset.
    always_comb begin
        o_init_done = 1'b0;
        mem_clr     = 1'b0;
        wr_acc      = 1'b0;
        rd_acc      = 1'b0;
        if (state == S_READY) begin
            o_init_done = 1'b1;
            wr_acc      = i_wen & i_rstn;
            rd_acc      = i_ren & i_rstn;
        end else begin
            mem_clr     = i_rstn;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            clr_addr <= '0;
        end else if (state == S_CLEAR) begin
            clr_addr <= clr_addr + BW_ADDR'(1);
        end
    end

    always_comb begin
        wr_merged = mem[i_waddr];
        for (int k = 0; k < NB; k++) begin
            if (i_wbe[k]) begin
                wr_merged[8*k +: 8] = i_wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem[i_raddr];
        if (BYPASS != 0 && wr_acc && (i_waddr == i_raddr)) begin
            rd_word = wr_merged;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_clr) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            mem[i_waddr] <= wr_merged;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic               stg_vld;
            logic [BW_DATA-1:0] stg_data;

            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    stg_vld  <= 1'b0;
                    stg_data <= '0;
                end else begin
                    stg_vld <= rd_acc;
                    if (rd_acc) begin
                        stg_data <= rd_word;
                    end
                end
            end

            assign pipe_vld  = stg_vld;
            assign pipe_data = stg_data;
        end else begin : g_lat1
            assign pipe_vld  = rd_acc;
            assign pipe_data = rd_word;
        end
    endgenerate

    // o_rdata holds its last value between completions so it never goes X.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
        end else begin
            o_rvalid <= pipe_vld;
            if (pipe_vld) begin
                o_rdata <= pipe_data;
            end
        end
    end

endmodule

// File: tb/tb_tpsram_be.sv
// tb/tb_tpsram_be.sv - directed self-checking bench for tpsram_be
module tb_tpsram_be;

    logic        i_clk;
    logic        rst_a;
    logic        rst_b;
    logic        i_wen;
    logic [3:0]  i_waddr;
    logic [31:0] i_wdata;
    logic [3:0]  i_wbe;
    logic        i_ren;
    logic [3:0]  i_raddr;

    logic [31:0] rdata0, rdata1, rdata2;
    logic        rvalid0, rvalid1, rvalid2;
    logic        done0, done1, done2;

    int checks = 0;
    int errors = 0;
    int early;
    int bad_vld;

    // u0: defaults; u1: RD_LAT=2, BYPASS=0; u2: RD_LAT=2, INIT_CLEAR=0 on its own reset
    tpsram_be u0 (
        .i_clk(i_clk), .i_rstn(rst_a), .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_wbe(i_wbe), .i_ren(i_ren), .i_raddr(i_raddr),
        .o_rdata(rdata0), .o_rvalid(rvalid0), .o_init_done(done0)
    );

    tpsram_be #(.RD_LAT(2), .BYPASS(0)) u1 (
        .i_clk(i_clk), .i_rstn(rst_a), .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_wbe(i_wbe), .i_ren(i_ren), .i_raddr(i_raddr),
        .o_rdata(rdata1), .o_rvalid(rvalid1), .o_init_done(done1)
    );

    tpsram_be #(.RD_LAT(2), .INIT_CLEAR(0)) u2 (
        .i_clk(i_clk), .i_rstn(rst_b), .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_wbe(i_wbe), .i_ren(i_ren), .i_raddr(i_raddr),
        .o_rdata(rdata2), .o_rvalid(rvalid2), .o_init_done(done2)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        i_wen = 1'b1; i_waddr = a; i_wdata = d; i_wbe = be;
        tick();
        i_wen = 1'b0;
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        i_wen = 1'b0; i_waddr = '0; i_wdata = '0; i_wbe = '0;
        i_ren = 1'b0; i_raddr = '0;
        tick();
        tick();

        chk("rst_done0", {31'b0, done0}, 32'd0);
        chk("rst_vld0", {31'b0, rvalid0}, 32'd0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_vld1", {31'b0, rvalid1}, 32'd0);
        chk("rst_done2", {31'b0, done2}, 32'd1);
        chk("rst_rdata2", rdata2, 32'h0);

        // Test 1: clear takes exactly 16 edges, then all words read zero
        rst_a = 1'b1;
        early = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (done0 !== 1'b0) early++;
        end
        chk("clr_early", early, 0);
        tick();
        chk("clr_done16", {31'b0, done0}, 32'd1);
        chk("clr_done16_u1", {31'b0, done1}, 32'd1);

        bad_vld = 0;
        for (int a = 0; a < 16; a++) begin
            i_ren = 1'b1; i_raddr = 4'(a);
            tick();
            if (rvalid0 !== 1'b1 || rdata0 !== 32'h0) bad_vld++;
        end
        chk("clr_read_all", bad_vld, 0);
        i_ren = 1'b0;
        tick();
        chk("idle_vld0", {31'b0, rvalid0}, 32'd0);
        chk("tail_vld1", {31'b0, rvalid1}, 32'd1);
        chk("idle_hold0", rdata0, 32'h0);

        // Test 2: byte-enable merge
        wr(4'd3, 32'hAABBCCDD, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        i_ren = 1'b1; i_raddr = 4'd3;
        tick();
        i_ren = 1'b0;
        chk("be_merge_u0", rdata0, 32'hAA22CC44);
        chk("be_merge_vld0", {31'b0, rvalid0}, 32'd1);
        tick();
        chk("be_merge_u1", rdata1, 32'hAA22CC44);

        // Test 3: same-address read-during-write
        i_wen = 1'b1; i_waddr = 4'd5; i_wdata = 32'hFFFFFFFF; i_wbe = 4'b0011;
        i_ren = 1'b1; i_raddr = 4'd5;
        tick();
        i_wen = 1'b0;
        chk("rdw_bypass1", rdata0, 32'h0000FFFF);
        tick();
        i_ren = 1'b0;
        chk("rdw_bypass0", rdata1, 32'h00000000);
        chk("rdw_next_u0", rdata0, 32'h0000FFFF);
        tick();
        chk("rdw_next_u1", rdata1, 32'h0000FFFF);

        // Test 4: RD_LAT=2 streaming
        wr(4'd1, 32'h1, 4'hF);
        wr(4'd2, 32'h2, 4'hF);
        wr(4'd3, 32'h3, 4'hF);
        i_ren = 1'b1; i_raddr = 4'd1;
        tick();
        chk("l2_first_vld", {31'b0, rvalid1}, 32'd0);
        i_raddr = 4'd2;
        tick();
        chk("l2_d1", rdata1, 32'h1);
        chk("l2_v1", {31'b0, rvalid1}, 32'd1);
        i_raddr = 4'd3;
        tick();
        i_ren = 1'b0;
        chk("l2_d2", rdata1, 32'h2);
        chk("l2_v2", {31'b0, rvalid1}, 32'd1);
        tick();
        chk("l2_d3", rdata1, 32'h3);
        chk("l2_v3", {31'b0, rvalid1}, 32'd1);
        tick();
        chk("l2_hold_d", rdata1, 32'h3);
        chk("l2_hold_v", {31'b0, rvalid1}, 32'd0);

        // Test 5: reset mid-clear restarts the sequence
        wr(4'd15, 32'hDEADBEEF, 4'hF);
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        rst_a = 1'b0;
        #1;
        chk("midclr_rst_done", {31'b0, done0}, 32'd0);
        #1;
        rst_a = 1'b1;
        i_wen = 1'b1; i_waddr = 4'd2; i_wdata = 32'hFFFFFFFF; i_wbe = 4'hF;
        i_ren = 1'b1; i_raddr = 4'd2;
        early = 0;
        bad_vld = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (done0 !== 1'b0) early++;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) bad_vld++;
        end
        tick();
        i_wen = 1'b0; i_ren = 1'b0;
        if (rvalid0 !== 1'b0) bad_vld++;
        chk("reclr_early", early, 0);
        chk("reclr_done", {31'b0, done0}, 32'd1);
        chk("reclr_no_vld", bad_vld, 0);
        i_ren = 1'b1; i_raddr = 4'd2;
        tick();
        chk("reclr_a2", rdata0, 32'h0);
        i_raddr = 4'd15;
        tick();
        i_ren = 1'b0;
        chk("reclr_a15", rdata0, 32'h0);
        chk("reclr_a15_vld", {31'b0, rvalid0}, 32'd1);

        // Test 6: INIT_CLEAR=0 instance
        tick();
        rst_b = 1'b1;
        chk("nc_done", {31'b0, done2}, 32'd1);
        wr(4'd7, 32'h12345678, 4'hF);
        i_ren = 1'b1; i_raddr = 4'd7;
        tick();
        i_ren = 1'b0;
        tick();
        chk("nc_rd", rdata2, 32'h12345678);
        chk("nc_rd_vld", {31'b0, rvalid2}, 32'd1);
        i_ren = 1'b1; i_raddr = 4'd7;
        tick();
        i_ren = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("nc_rst_vld", {31'b0, rvalid2}, 32'd0);
        chk("nc_rst_rdata", rdata2, 32'h0);
        #1;
        rst_b = 1'b1;
        tick();
        chk("nc_flushed_vld", {31'b0, rvalid2}, 32'd0);
        chk("nc_flushed_done", {31'b0, done2}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
